sensor_acq_ctrl: RTL
====================

SENSOR_ACQ_CTRL -- requirements
Module: sensor_acq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sensor sample width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the settle, timeout and sample counters.
REQ-003 SHALL provide port clk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL provide port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL provide port trigger, input, 1: one-cycle acquisition request from the timing manager.
REQ-006 SHALL provide port en, input, 1: sensor enable bit from the timing manager.
REQ-007 SHALL provide port settle_cycles, input, CNT_W: delay N between trigger and conversion start.
REQ-008 SHALL provide port timeout_cycles, input, CNT_W: maximum wait for data_valid; 0 disables the timeout.
REQ-009 SHALL provide port conv_start, output, 1: one-cycle start pulse to the sensor front-end.
REQ-010 SHALL provide ports data_valid (input, 1) and data_in (input, DATA_W): sample returned by the front-end.
REQ-011 SHALL provide port done, output, 1: level signal back to the timing manager.
REQ-012 SHALL provide port data_out, output, DATA_W: last captured sample.
REQ-013 SHALL provide ports timeout_flag (output, 1), overrun_count (output, 8) and sample_count (output, CNT_W).

Function
REQ-014 SHALL implement states IDLE, SETTLE, WAIT and DONE; all outputs SHALL be registered.
REQ-015 In IDLE or DONE, an edge sampling trigger=1 with en=1 SHALL enter SETTLE, clear the settle counter, and drive done=0 and timeout_flag=0 on the next cycle.
REQ-016 A trigger sampled while en=0 SHALL be ignored; the state SHALL stay unchanged.
REQ-017 In SETTLE, the state SHALL advance to WAIT once the counter equals settle_cycles; conv_start SHALL be high exactly one cycle, N+1 cycles after the trigger edge (N=0 gives 1).
REQ-018 In WAIT, data_valid SHALL be sampled every cycle, including the conv_start cycle; values outside WAIT SHALL be ignored.
REQ-019 When data_valid=1 is sampled in WAIT, data_out SHALL capture data_in, sample_count SHALL increment (wrapping at 2^CNT_W-1 to 0), and the next state SHALL be DONE with done=1 and timeout_flag=0.
REQ-020 When timeout_cycles!=0 and the WAIT counter reaches timeout_cycles, the next state SHALL be DONE with done=1 and timeout_flag=1; data_out and sample_count SHALL be held.
REQ-021 When data_valid and the timeout occur on the same edge, data_valid SHALL take priority (REQ-019).
REQ-022 When timeout_cycles=0, WAIT SHALL persist until data_valid arrives.
REQ-023 A trigger sampled in SETTLE or WAIT SHALL be dropped, overrun_count SHALL increment, and overrun_count SHALL saturate at 255.
REQ-024 If en is sampled low in SETTLE or WAIT, the block SHALL abort to IDLE with done=0 and no capture; a conv_start pulse already issued is not recalled.
REQ-025 done SHALL remain high in DONE until the next accepted trigger.
REQ-026 settle_cycles and timeout_cycles SHALL be sampled live each cycle; software changes them only while the block is in IDLE.

Reset
REQ-027 While rst=1, the state SHALL be IDLE, and done, conv_start, timeout_flag, data_out, overrun_count, sample_count and all internal counters SHALL be 0.
REQ-028 Reset asserted mid-acquisition SHALL abort immediately with no capture; operation SHALL resume on the first edge after rst deasserts.

Structure
REQ-029 The state enum, CNT_W default and overrun width SHALL live in the shared package sensor_acq_pkg.
REQ-030 The settle and timeout counting SHALL use one instance each of sub-module acq_cycle_counter (clear, enable, compare-equal output).

Verification
REQ-031 Settle=3, timeout=0, trigger at edge 0, data_valid with 0xA5A5_0001 two cycles after conv_start -> conv_start at cycle 4; done=1 and data_out=0xA5A5_0001 one cycle after data_valid; sample_count=1.
REQ-032 Settle=0, timeout=5, no data_valid -> done=1 and timeout_flag=1 six cycles after conv_start; data_out unchanged.
REQ-033 Timeout=5 with data_valid on the timeout edge -> timeout_flag=0 and the sample captured.
REQ-034 Three triggers during WAIT, then 300 triggers during WAIT -> overrun_count=3, then 255.
REQ-035 en dropped during SETTLE; rst pulsed during WAIT -> IDLE, done=0, no conv_start (SETTLE case), all outputs 0 after reset.
REQ-036 Preload sample_count=0xFFFF and complete one capture -> sample_count=0x0000.

Source files
------------

// File: rtl/sensor_acq_pkg.sv
// Shared types and constants for the sensor acquisition controller.
package sensor_acq_pkg;

  // Default width of the settle, timeout and sample counters.
  localparam int CNT_W_DEF = 16;

  // Width of the saturating overrun counter.
  localparam int OVR_W = 8;

  // Acquisition sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } acq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] value);
    return (value == '1) ? value : value + OVR_W'(1);
  endfunction

endpackage : sensor_acq_pkg

// File: rtl/acq_cycle_counter.sv
// Free-running cycle counter with synchronous clear, count enable and an
// equality compare against a live target value.
module acq_cycle_counter
  import sensor_acq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_equal
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear wins over enable so a restart always begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Compare against the target sampled live this cycle.
  assign o_equal = (r_count == i_target);

endmodule : acq_cycle_counter

// File: rtl/sensor_acq_ctrl.sv
// Sensor acquisition controller: on an accepted trigger waits a settle
// period, pulses conv_start, then waits for the front-end sample or a
// timeout and reports completion to the timing manager.
module sensor_acq_ctrl
  import sensor_acq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              en,
  input  logic [CNT_W-1:0]  settle_cycles,
  input  logic [CNT_W-1:0]  timeout_cycles,
  output logic              conv_start,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              timeout_flag,
  output logic [OVR_W-1:0]  overrun_count,
  output logic [CNT_W-1:0]  sample_count
);

  acq_state_t        r_state;
  logic              r_conv_start;
  logic              r_done;
  logic              r_timeout_flag;
  logic [DATA_W-1:0] r_data_out;
  logic [OVR_W-1:0]  r_overrun_count;
  logic [CNT_W-1:0]  r_sample_count;

  logic w_idle_or_done;
  logic w_busy;
  logic w_accept;
  logic w_settle_eq;
  logic w_wait_eq;
  logic w_settle_clr;
  logic w_settle_en;
  logic w_wait_clr;
  logic w_wait_en;
  logic w_timeout;

  // Trigger qualification and counter control derived from current state.
  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_busy         = (r_state == ST_SETTLE) || (r_state == ST_WAIT);
  assign w_accept       = w_idle_or_done && trigger && en;
  assign w_settle_clr   = w_accept;
  assign w_settle_en    = (r_state == ST_SETTLE);
  assign w_wait_clr     = (r_state == ST_SETTLE) && en && w_settle_eq;
  assign w_wait_en      = (r_state == ST_WAIT);
  assign w_timeout      = (timeout_cycles != '0) && w_wait_eq;

  acq_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_settle_clr),
    .i_enable (w_settle_en),
    .i_target (settle_cycles),
    .o_equal  (w_settle_eq)
  );

  acq_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wait_clr),
    .i_enable (w_wait_en),
    .i_target (timeout_cycles),
    .o_equal  (w_wait_eq)
  );

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_conv_start    <= 1'b0;
      r_done          <= 1'b0;
      r_timeout_flag  <= 1'b0;
      r_data_out      <= '0;
      r_overrun_count <= '0;
      r_sample_count  <= '0;
    end else begin
      // conv_start is a single-cycle pulse unless the settle exit re-arms it.
      r_conv_start <= 1'b0;

      // A trigger arriving mid-acquisition is dropped but recorded.
      if (w_busy && trigger && en) begin
        r_overrun_count <= sat_inc(r_overrun_count);
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (trigger && en) begin
            r_state        <= ST_SETTLE;
            r_done         <= 1'b0;
            r_timeout_flag <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (!en) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else if (w_settle_eq) begin
            r_state      <= ST_WAIT;
            r_conv_start <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (!en) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else if (data_valid) begin
            // A sample on the timeout edge still counts as a capture.
            r_state        <= ST_DONE;
            r_done         <= 1'b1;
            r_timeout_flag <= 1'b0;
            r_data_out     <= data_in;
            r_sample_count <= r_sample_count + CNT_W'(1);
          end else if (w_timeout) begin
            r_state        <= ST_DONE;
            r_done         <= 1'b1;
            r_timeout_flag <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign conv_start    = r_conv_start;
  assign done          = r_done;
  assign timeout_flag  = r_timeout_flag;
  assign data_out      = r_data_out;
  assign overrun_count = r_overrun_count;
  assign sample_count  = r_sample_count;

endmodule : sensor_acq_ctrl
